// File: rtl/fetch_sequencer.sv
// Instruction-fetch sequencer: owns the PC, issues one imem request per
// instruction, hands fetched words to decode, and arbitrates sequential,
// redirect and trap-entry PC updates (killing in-flight fetches on redirect).
module fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int unsigned MAX_WAIT     = 15
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_imem_req,
   output logic [31:0] o_imem_addr,
   input  logic        i_imem_ack,
   input  logic        i_imem_err,
   input  logic [31:0] i_imem_rdata,
   output logic        o_inst_valid,
   output logic [31:0] o_inst,
   output logic [31:0] o_inst_pc,
   input  logic        i_inst_ready,
   input  logic        i_stall,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   input  logic [31:0] i_trap_vec,
   output logic        o_fetch_fault,
   output logic [31:0] o_fault_pc
);

   typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

   // Last WAIT cycle index before a missing ack becomes a timeout.
   localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

   state_t      state, state_nx;
   logic [31:0] pc, pc_nx;
   logic        kill, kill_nx;
   logic [31:0] kill_pc, kill_pc_nx;
   logic [7:0]  wait_cnt, wait_cnt_nx;
   logic        inst_valid_nx, fetch_fault_nx;
   logic [31:0] inst_nx, inst_pc_nx, fault_pc_nx;
   logic [31:0] redirect_tgt;

   // Redirect targets are always word aligned.
   assign redirect_tgt = i_redirect_pc & 32'hFFFF_FFFC;

   // Request strobe and address come straight from state and PC so a fetch
   // launches in the same cycle the sequencer decides to issue it.
   assign o_imem_addr = pc;
   assign o_imem_req  = (state == REQ) && !i_redirect && !i_stall && !i_rst;

   // Next-state, PC arbitration and registered-output next values.
   always_comb begin
      state_nx       = state;
      pc_nx          = pc;
      kill_nx        = kill;
      kill_pc_nx     = kill_pc;
      wait_cnt_nx    = wait_cnt;
      inst_valid_nx  = o_inst_valid;
      inst_nx        = o_inst;
      inst_pc_nx     = o_inst_pc;
      fetch_fault_nx = 1'b0;
      fault_pc_nx    = o_fault_pc;
      case (state)
         BOOT: state_nx = REQ;
         REQ: begin
            if (i_redirect) begin
               pc_nx = redirect_tgt;
            end else if (!i_stall) begin
               state_nx    = WAIT;
               wait_cnt_nx = 8'd0;
            end
         end
         WAIT: begin
            if (i_imem_ack && (kill || i_redirect)) begin
               // Stale fetch: drop data and any error, go to the newest target.
               pc_nx    = i_redirect ? redirect_tgt : kill_pc;
               kill_nx  = 1'b0;
               state_nx = REQ;
            end else if (i_imem_ack && i_imem_err) begin
               fetch_fault_nx = 1'b1;
               fault_pc_nx    = pc;
               pc_nx          = i_trap_vec;
               state_nx       = REQ;
            end else if (i_imem_ack) begin
               inst_nx       = i_imem_rdata;
               inst_pc_nx    = pc;
               inst_valid_nx = 1'b1;
               state_nx      = HOLD;
            end else if (i_redirect) begin
               // Cannot abort the bus cycle; remember where to go once it ends.
               kill_nx    = 1'b1;
               kill_pc_nx = redirect_tgt;
            end else if (wait_cnt == WAIT_LAST) begin
               kill_nx  = 1'b0;
               state_nx = REQ;
               if (kill) begin
                  pc_nx = kill_pc;
               end else begin
                  fetch_fault_nx = 1'b1;
                  fault_pc_nx    = pc;
                  pc_nx          = i_trap_vec;
               end
            end else begin
               wait_cnt_nx = wait_cnt + 8'd1;
            end
         end
         HOLD: begin
            if (i_redirect) begin
               pc_nx         = redirect_tgt;
               inst_valid_nx = 1'b0;
               state_nx      = REQ;
            end else if (i_inst_ready) begin
               pc_nx         = pc + 32'd4;
               inst_valid_nx = 1'b0;
               state_nx      = REQ;
            end
         end
         default: state_nx = BOOT;
      endcase
   end

   // State, PC and registered outputs; reset abandons any outstanding fetch.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state         <= BOOT;
         pc            <= RESET_VECTOR;
         kill          <= 1'b0;
         kill_pc       <= 32'd0;
         wait_cnt      <= 8'd0;
         o_inst_valid  <= 1'b0;
         o_inst        <= 32'd0;
         o_inst_pc     <= 32'd0;
         o_fetch_fault <= 1'b0;
         o_fault_pc    <= 32'd0;
      end else begin
         state         <= state_nx;
         pc            <= pc_nx;
         kill          <= kill_nx;
         kill_pc       <= kill_pc_nx;
         wait_cnt      <= wait_cnt_nx;
         o_inst_valid  <= inst_valid_nx;
         o_inst        <= inst_nx;
         o_inst_pc     <= inst_pc_nx;
         o_fetch_fault <= fetch_fault_nx;
         o_fault_pc    <= fault_pc_nx;
      end
   end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Testbench for fetch_sequencer: directed scenarios followed by random
// stimulus, every cycle compared against a transaction-level model.
module tb_fetch_sequencer;

   localparam int MAXW = 4;

   logic        clk;
   logic        rst, stall, redirect, ack, err, ready;
   logic [31:0] redirect_pc, rdata, tvec;
   logic        req, inst_valid, fault;
   logic [31:0] addr, inst, inst_pc, fault_pc;

   int tests = 0;
   int fails = 0;

   fetch_sequencer #(.RESET_VECTOR(32'h0000_0000), .MAX_WAIT(MAXW)) dut (
      .i_clk(clk), .i_rst(rst),
      .o_imem_req(req), .o_imem_addr(addr),
      .i_imem_ack(ack), .i_imem_err(err), .i_imem_rdata(rdata),
      .o_inst_valid(inst_valid), .o_inst(inst), .o_inst_pc(inst_pc),
      .i_inst_ready(ready), .i_stall(stall),
      .i_redirect(redirect), .i_redirect_pc(redirect_pc),
      .i_trap_vec(tvec),
      .o_fetch_fault(fault), .o_fault_pc(fault_pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: a fetch is either booting, outstanding on the bus,
   // parked in the decode buffer, or about to be requested.
   logic [31:0] m_pc;
   logic        m_boot, m_out, m_hold;
   logic [31:0] kill_q[$];
   int          m_waited;
   logic        m_valid, m_fault;
   logic [31:0] m_inst, m_inst_pc, m_fault_pc;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_trap();
      m_fault    = 1'b1;
      m_fault_pc = m_pc;
      m_pc       = tvec;
      m_out      = 1'b0;
   endtask

   task automatic model_edge();
      logic [31:0] tgt;
      tgt = {redirect_pc[31:2], 2'b00};
      if (rst) begin
         m_boot = 1; m_out = 0; m_hold = 0; m_pc = 32'h0; m_waited = 0;
         kill_q.delete();
         m_valid = 0; m_inst = 0; m_inst_pc = 0; m_fault = 0; m_fault_pc = 0;
      end else begin
         m_fault = 1'b0;
         if (m_boot) begin
            m_boot = 1'b0;
         end else if (m_out) begin
            if (ack && (kill_q.size() > 0 || redirect)) begin
               m_pc  = redirect ? tgt : kill_q[0];
               kill_q.delete();
               m_out = 1'b0;
            end else if (ack && err) begin
               model_trap();
            end else if (ack) begin
               m_inst = rdata; m_inst_pc = m_pc; m_valid = 1'b1;
               m_out = 1'b0; m_hold = 1'b1;
            end else if (redirect) begin
               kill_q.delete();
               kill_q.push_back(tgt);
            end else if (m_waited == MAXW - 1) begin
               if (kill_q.size() > 0) begin
                  m_pc  = kill_q[0];
                  kill_q.delete();
                  m_out = 1'b0;
               end else begin
                  model_trap();
               end
            end else begin
               m_waited++;
            end
         end else if (m_hold) begin
            if (redirect) begin
               m_pc = tgt; m_hold = 0; m_valid = 0;
            end else if (ready) begin
               m_pc = m_pc + 32'd4; m_hold = 0; m_valid = 0;
            end
         end else begin
            if (redirect) m_pc = tgt;
            else if (!stall) begin
               m_out = 1'b1; m_waited = 0;
            end
         end
      end
   endtask

   // Settle after input changes, then compare every output against the model.
   task automatic look();
      logic exp_req;
      #1;
      exp_req = !rst && !m_boot && !m_out && !m_hold && !redirect && !stall;
      chk("m_req", {31'd0, req}, {31'd0, exp_req});
      chk("m_addr", addr, m_pc);
      chk("m_valid", {31'd0, inst_valid}, {31'd0, m_valid});
      chk("m_inst", inst, m_inst);
      chk("m_inst_pc", inst_pc, m_inst_pc);
      chk("m_fault", {31'd0, fault}, {31'd0, m_fault});
      chk("m_fault_pc", fault_pc, m_fault_pc);
   endtask

   task automatic adv();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   initial begin
      rst = 1; stall = 0; redirect = 0; ack = 0; err = 0; ready = 0;
      redirect_pc = 0; rdata = 0; tvec = 0;
      adv(); adv();
      look();
      chk("rst_req", {31'd0, req}, 32'd0);
      chk("rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("rst_addr", addr, 32'h0);

      // Sequential fetch, ack after one WAIT cycle, ready held high.
      rst = 0; ready = 1;
      look(); chk("boot_req", {31'd0, req}, 32'd0); adv();
      for (int k = 0; k < 3; k++) begin
         look();
         chk("seq_req", {31'd0, req}, 32'd1);
         chk("seq_addr", addr, 32'(k * 4));
         adv();
         ack = 1; rdata = 32'hA000_0000 + 32'(k);
         look(); adv();
         ack = 0;
         look();
         chk("seq_valid", {31'd0, inst_valid}, 32'd1);
         chk("seq_inst_pc", inst_pc, 32'(k * 4));
         chk("seq_inst", inst, 32'hA000_0000 + 32'(k));
         adv();
      end
      ready = 0;

      // Redirect during WAIT, late ack with data that must be discarded.
      look(); chk("kill_addr0", addr, 32'hC); adv();
      redirect = 1; redirect_pc = 32'h100; look(); adv();
      redirect = 0; look(); adv();
      ack = 1; rdata = 32'hDEAD_BEEF; look(); adv();
      ack = 0;
      look();
      chk("kill_valid", {31'd0, inst_valid}, 32'd0);
      chk("kill_fault", {31'd0, fault}, 32'd0);
      chk("kill_addr", addr, 32'h100);

      // Bus error at 0x20 enters the trap vector.
      redirect = 1; redirect_pc = 32'h20;
      look(); chk("redir_noreq", {31'd0, req}, 32'd0); adv();
      redirect = 0; look(); chk("err_addr0", addr, 32'h20); adv();
      ack = 1; err = 1; tvec = 32'h80; look(); adv();
      ack = 0; err = 0;
      look();
      chk("err_fault", {31'd0, fault}, 32'd1);
      chk("err_fault_pc", fault_pc, 32'h20);
      chk("err_addr", addr, 32'h80);
      adv();

      // Timeout with no ack, then timeout after a redirect (no fault).
      tvec = 32'h300;
      for (int i = 0; i < MAXW; i++) begin
         look(); chk("to_nofault", {31'd0, fault}, 32'd0); adv();
      end
      look();
      chk("to_fault", {31'd0, fault}, 32'd1);
      chk("to_fault_pc", fault_pc, 32'h80);
      chk("to_addr", addr, 32'h300);
      adv();
      redirect = 1; redirect_pc = 32'h407; look(); adv();
      redirect = 0;
      for (int i = 0; i < MAXW; i++) begin
         look(); chk("tok_wait", {31'd0, req}, 32'd0); adv();
      end
      look();
      chk("tok_req", {31'd0, req}, 32'd1);
      chk("tok_addr", addr, 32'h404);
      chk("tok_fault", {31'd0, fault}, 32'd0);
      adv();

      // Decode back-pressure: HOLD stable for 5 cycles, then pc+4.
      ack = 1; rdata = 32'h1234_5678; look(); adv();
      ack = 0;
      for (int i = 0; i < 5; i++) begin
         look();
         chk("hold_valid", {31'd0, inst_valid}, 32'd1);
         chk("hold_inst", inst, 32'h1234_5678);
         chk("hold_inst_pc", inst_pc, 32'h404);
         adv();
      end
      ready = 1; look(); adv();
      ready = 0; look(); chk("hold_next", addr, 32'h408); adv();
      ack = 1; rdata = 32'hCAFE_0001; look(); adv();
      ack = 0; ready = 1; redirect = 1; redirect_pc = 32'h500; look(); adv();
      ready = 0; redirect = 0;
      look(); chk("hold_redir", addr, 32'h500);

      // Reset during WAIT; the following ack is ignored.
      adv();
      rst = 1; look(); adv();
      rst = 0; ack = 1; rdata = 32'h55;
      look();
      chk("mid_rst_valid", {31'd0, inst_valid}, 32'd0);
      chk("mid_rst_inst", inst, 32'd0);
      chk("mid_rst_inst_pc", inst_pc, 32'd0);
      chk("mid_rst_fault_pc", fault_pc, 32'd0);
      chk("mid_rst_req", {31'd0, req}, 32'd0);
      adv();
      ack = 0; look(); chk("refetch_addr", addr, 32'h0); chk("refetch_req", {31'd0, req}, 32'd1);

      // PC wrap from 0xFFFFFFFC to 0.
      redirect = 1; redirect_pc = 32'hFFFF_FFFF; look(); adv();
      redirect = 0; look(); chk("wrap_addr0", addr, 32'hFFFF_FFFC); adv();
      ack = 1; rdata = 32'h0000_0013; look(); adv();
      ack = 0; ready = 1; look(); chk("wrap_inst_pc", inst_pc, 32'hFFFF_FFFC); adv();
      ready = 0; look(); chk("wrap_addr", addr, 32'h0);

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         adv();
         rst         = ($urandom_range(99) == 0);
         stall       = ($urandom_range(3) == 0);
         redirect    = ($urandom_range(9) == 0);
         redirect_pc = $urandom;
         ack         = ($urandom_range(2) == 0);
         err         = ($urandom_range(4) == 0);
         rdata       = $urandom;
         ready       = ($urandom_range(1) == 0);
         tvec        = $urandom & 32'hFFFF_FFFC;
         look();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
